// File: rtl/div_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; results stay registered until the next division completes.
module div_seq #(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
  output logic             dz
);

  localparam int unsigned QW = 2 * N;
  localparam int unsigned CW = $clog2(QW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [QW-1:0]   q, q_d;
  logic [N-1:0]    d, d_d;
  logic [N-1:0]    r, r_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            busy_d, done_d, dz_d;
  logic [QW-1:0]   quo_d;
  logic [N-1:0]    rem_d;
  logic [N:0]      t;
  logic [N:0]      t_sub;

  // Shifted partial remainder carries the extra bit so the compare never overflows;
  // after a subtract the result is always below D and fits back into N bits.
  always_comb begin
    t     = {r, q[QW-1]};
    t_sub = t - {1'b0, d};
  end

  // State and datapath register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      q         <= '0;
      d         <= '0;
      r         <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
    end else begin
      state     <= state_d;
      q         <= q_d;
      d         <= d_d;
      r         <= r_d;
      cnt       <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      quotient  <= quo_d;
      remainder <= rem_d;
      dz        <= dz_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    q_d     = q;
    d_d     = d;
    r_d     = r;
    cnt_d   = cnt;
    busy_d  = busy;
    done_d  = 1'b0;
    quo_d   = quotient;
    rem_d   = remainder;
    dz_d    = dz;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = '0;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = dividend;
            d_d     = divisor;
            r_d     = '0;
            cnt_d   = CW'(QW);
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (t >= {1'b0, d}) begin
          r_d = t_sub[N-1:0];
          q_d = {q[QW-2:0], 1'b1};
        end else begin
          r_d = t[N-1:0];
          q_d = {q[QW-2:0], 1'b0};
        end
        cnt_d = cnt - CW'(1);
        // Last iteration publishes the result in the same edge
        if (cnt == CW'(1)) begin
          quo_d   = q_d;
          rem_d   = r_d;
          dz_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus randomized divisions
// compared against plain integer division.
module tb_div_seq;

  localparam int unsigned N  = 8;
  localparam int unsigned QW = 2 * N;
  localparam int LAT = 2 * N;

  logic            clk;
  logic            reset;
  logic            start;
  logic [QW-1:0]   dividend;
  logic [N-1:0]    divisor;
  logic            busy;
  logic            done;
  logic [QW-1:0]   quotient;
  logic [N-1:0]    remainder;
  logic            dz;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  div_seq #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start pulse and collect the outcome; performs no comparisons itself.
  task automatic launch(input logic [QW-1:0] dvd, input logic [N-1:0] dvs,
                        output logic [QW-1:0] oq, output logic [N-1:0] orm,
                        output logic odz, output int lat,
                        output bit busy_ok, output bit pulse_ok);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    tick();
    start    = 1'b0;
    dividend = QW'($urandom);
    divisor  = N'($urandom);
    lat      = 0;
    busy_ok  = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    oq       = quotient;
    orm      = remainder;
    odz      = dz;
    pulse_ok = (busy === 1'b0);
    tick();
    pulse_ok = pulse_ok && (done === 1'b0) && (quotient === oq);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    dividend = 16'd50;
    divisor  = 8'd5;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    n_checks++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL reset_dz got=%b exp=0", dz); end
    start = 1'b0;
    reset = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_release busy=%b done=%b exp=0/0", busy, done); end
  endtask

  task automatic test_basic();
    logic [QW-1:0] oq; logic [N-1:0] orm; logic odz; int lat; bit bok, pok;
    launch(16'd1000, 8'd7, oq, orm, odz, lat, bok, pok);
    n_checks++; if (oq !== 16'd142) begin n_fail++; $display("FAIL basic_quotient got=%0d exp=142", oq); end
    n_checks++; if (orm !== 8'd6) begin n_fail++; $display("FAIL basic_remainder got=%0d exp=6", orm); end
    n_checks++; if (odz !== 1'b0) begin n_fail++; $display("FAIL basic_dz got=%b exp=0", odz); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
    n_checks++; if (!bok) begin n_fail++; $display("FAIL basic_busy got=dropped exp=high_throughout"); end
    n_checks++; if (!pok) begin n_fail++; $display("FAIL basic_done_pulse got=bad exp=one_cycle"); end
  endtask

  task automatic test_boundary();
    logic [QW-1:0] oq; logic [N-1:0] orm; logic odz; int lat; bit bok, pok;
    logic [QW-1:0] dv [3];
    logic [N-1:0]  ds [3];
    logic [QW-1:0] eq [3];
    logic [N-1:0]  er [3];
    dv[0] = 16'hFFFF; ds[0] = 8'h01; eq[0] = 16'hFFFF; er[0] = 8'd0;
    dv[1] = 16'hFFFF; ds[1] = 8'hFF; eq[1] = 16'h0101; er[1] = 8'd0;
    dv[2] = 16'd12;   ds[2] = 8'd200; eq[2] = 16'd0;  er[2] = 8'd12;
    for (int i = 0; i < 3; i++) begin
      launch(dv[i], ds[i], oq, orm, odz, lat, bok, pok);
      n_checks++;
      if (oq !== eq[i] || orm !== er[i] || odz !== 1'b0 || lat !== LAT) begin
        n_fail++;
        $display("FAIL boundary_%0d got q=%h r=%h dz=%b lat=%0d exp q=%h r=%h dz=0 lat=%0d",
                 i, oq, orm, odz, lat, eq[i], er[i], LAT);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [QW-1:0] oq; logic [N-1:0] orm; logic odz; int lat; bit bok, pok;
    launch(16'h1234, 8'd0, oq, orm, odz, lat, bok, pok);
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL dz_latency got=%0d exp=0", lat); end
    n_checks++; if (odz !== 1'b1) begin n_fail++; $display("FAIL dz_flag got=%b exp=1", odz); end
    n_checks++; if (oq !== 16'hFFFF || orm !== 8'd0) begin n_fail++; $display("FAIL dz_result got q=%h r=%h exp q=ffff r=0", oq, orm); end
    n_checks++; if (!pok) begin n_fail++; $display("FAIL dz_done_pulse got=bad exp=one_cycle_no_busy"); end
    launch(16'd100, 8'd10, oq, orm, odz, lat, bok, pok);
    n_checks++;
    if (oq !== 16'd10 || orm !== 8'd0 || odz !== 1'b0 || lat !== LAT) begin
      n_fail++;
      $display("FAIL dz_recover got q=%0d r=%0d dz=%b lat=%0d exp q=10 r=0 dz=0 lat=%0d", oq, orm, odz, lat, LAT);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    bit held_ok;
    held_ok = 1'b1;
    start = 1'b1; dividend = 16'd5000; divisor = 8'd9;
    tick();
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      if (quotient !== 16'd10 || remainder !== 8'd0) held_ok = 1'b0;
      tick(); lat++;
    end
    start = 1'b1; dividend = 16'd77; divisor = 8'd3;
    tick(); lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      if (done !== 1'b1 && quotient !== 16'd10) held_ok = 1'b0;
      tick(); lat++;
    end
    n_checks++; if (!held_ok) begin n_fail++; $display("FAIL ignore_prev_held got=changed exp=q10_r0_held"); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, LAT); end
    n_checks++;
    if (quotient !== 16'd555 || remainder !== 8'd5) begin
      n_fail++; $display("FAIL ignore_result got q=%0d r=%0d exp q=555 r=5", quotient, remainder);
    end
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ignore_idle busy=%b done=%b exp=0/0", busy, done); end
  endtask

  task automatic test_reset_abort();
    logic [QW-1:0] oq; logic [N-1:0] orm; logic odz; int lat; bit bok, pok;
    bit saw_done;
    start = 1'b1; dividend = 16'd40000; divisor = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async got busy=%b done=%b q=%h r=%h dz=%b exp all 0", busy, done, quotient, remainder, dz);
    end
    start = 1'b1; dividend = 16'd9; divisor = 8'd2;
    tick(); tick();
    reset = 1'b0;
    start = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      tick();
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL abort_no_done got=activity exp=idle"); end
    launch(16'd255, 8'd16, oq, orm, odz, lat, bok, pok);
    n_checks++;
    if (oq !== 16'd15 || orm !== 8'd15 || odz !== 1'b0 || lat !== LAT) begin
      n_fail++;
      $display("FAIL abort_recover got q=%0d r=%0d dz=%b lat=%0d exp q=15 r=15 dz=0 lat=%0d", oq, orm, odz, lat, LAT);
    end
  endtask

  task automatic test_random();
    logic [QW-1:0] oq; logic [N-1:0] orm; logic odz; int lat; bit bok, pok;
    logic [QW-1:0] dvd, eq; logic [N-1:0] dvs, er; logic edz; int elat;
    for (int i = 0; i < 30; i++) begin
      dvd = QW'($urandom);
      dvs = (i % 7 == 3) ? '0 : N'($urandom);
      if (dvs == '0) begin
        eq = '1; er = '0; edz = 1'b1; elat = 0;
      end else begin
        eq = dvd / QW'(dvs); er = N'(dvd % QW'(dvs)); edz = 1'b0; elat = LAT;
      end
      launch(dvd, dvs, oq, orm, odz, lat, bok, pok);
      n_checks++;
      if (oq !== eq || orm !== er || odz !== edz || lat !== elat || !pok || !bok) begin
        n_fail++;
        $display("FAIL random_%0d %0d/%0d got q=%0d r=%0d dz=%b lat=%0d exp q=%0d r=%0d dz=%b lat=%0d",
                 i, dvd, dvs, oq, orm, odz, lat, eq, er, edz, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t [2];
    int k;
    bit res_ok;
    res_ok = 1'b1;
    start = 1'b1; dividend = 16'd60001; divisor = 8'd250;
    for (int j = 0; j < 2; j++) begin
      k = 0;
      tick();
      while (done !== 1'b1 && k < 100) begin tick(); k++; end
      t[j] = cyc;
      if (quotient !== 16'd240 || remainder !== 8'd1 || dz !== 1'b0) res_ok = 1'b0;
    end
    start = 1'b0;
    n_checks++; if (t[1] - t[0] !== LAT + 2) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", t[1] - t[0], LAT + 2); end
    n_checks++; if (!res_ok) begin n_fail++; $display("FAIL b2b_result got q=%0d r=%0d exp q=240 r=1", quotient, remainder); end
    tick(); tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle busy=%b done=%b exp=0/0", busy, done); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
